// File: rtl/cp0_pkg.sv
// cp0_pkg: shared definitions for the CP0 exception/ERET sequencer.
//   - Stage index constants for the per-stage exception vectors.
//   - MIPS III ExcCode values used by the pipeline.
//   - Default general exception vector.
//   - Sequencer state enum and the debug struct exported by exc_flush_ctrl.
package cp0_pkg;

    localparam int STG_IF = 0;
    localparam int STG_ID = 1;
    localparam int STG_EX = 2;
    localparam int STG_M  = 3;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] VECTOR_ADDR_DEFAULT = 32'h8000_0180;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXC  = 2'd1,
        ERET = 2'd2
    } exc_state_e;

    // Debug view: current sequencer state plus the stage index that won
    // the most recent exception capture.
    typedef struct packed {
        exc_state_e state;
        logic [1:0] win;
    } exc_dbg_t;

endpackage

// File: rtl/exc_flush_ctrl_if.sv
// exc_flush_ctrl_if: CP0 register-update bus between the exception
// sequencer (master) and cp0 (slave).
//   status_exl     cp0 -> seq  current Status.EXL
//   epc_in         cp0 -> seq  current EPC (ERET target)
//   epc_we/wdata   seq -> cp0  EPC write
//   cause_we       seq -> cp0  Cause write strobe
//   cause_exccode  seq -> cp0  Cause.ExcCode data
//   cause_bd       seq -> cp0  Cause.BD data
//   exl_set/clr    seq -> cp0  Status.EXL set / clear strobes
// Strobes are single-cycle pulses; cp0 samples them on the rising clock
// edge with no back-pressure (no ready signal on this bus).
interface exc_flush_ctrl_if #(
    parameter int PC_W = 32
);
    logic            status_exl;
    logic [PC_W-1:0] epc_in;
    logic            epc_we;
    logic [PC_W-1:0] epc_wdata;
    logic            cause_we;
    logic [4:0]      cause_exccode;
    logic            cause_bd;
    logic            exl_set;
    logic            exl_clr;

    modport master (
        input  status_exl, epc_in,
        output epc_we, epc_wdata, cause_we, cause_exccode, cause_bd,
               exl_set, exl_clr
    );

    modport slave (
        output status_exl, epc_in,
        input  epc_we, epc_wdata, cause_we, cause_exccode, cause_bd,
               exl_set, exl_clr
    );
endinterface

// File: rtl/exc_prio_enc.sv
// exc_prio_enc: oldest-first priority encoder over the per-stage
// exception detects (M > EX > ID > IF).
//   det    in   4  per-stage detect, index 0=IF .. 3=M
//   valid  out  1  any detect set
//   idx    out  2  index of the oldest (highest-index) set bit
module exc_prio_enc
    import cp0_pkg::*;
(
    input  logic [3:0] det,
    output logic       valid,
    output logic [1:0] idx
);

    always_comb begin
        valid = |det;
        idx   = 2'(STG_IF);
        if (det[STG_M]) begin
            idx = 2'(STG_M);
        end else if (det[STG_EX]) begin
            idx = 2'(STG_EX);
        end else if (det[STG_ID]) begin
            idx = 2'(STG_ID);
        end
    end

endmodule

// File: rtl/exc_flush_ctrl.sv
// exc_flush_ctrl: exception / ERET sequencer for the IF+4-stage MIPS III
// pipeline. Picks the oldest excepting stage, drives the per-stage flushes,
// issues the CP0 EPC/Cause/EXL updates and redirects fetch to the
// exception vector or to EPC on ERET.
//
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   exc_det[4], exc_code[4][5],  per-stage exception info (0=IF..3=M)
//   exc_pc[4][PC_W], exc_bd[4]
//   eret_id, id_stall            ERET in ID, ID stall
//   cp0_bus (master)             CP0 update bus (see exc_flush_ctrl_if)
//   if/id/ex/m_flush             stage flushes
//   pc_redirect, _addr           fetch redirect and target
//   busy                         sequencer not IDLE
//   dbg                          state and captured winning stage
//   exc_count, eret_count        saturating event counters, only when
//                                EXC_CTRL_STATS_EN is defined
module exc_flush_ctrl
    import cp0_pkg::*;
#(
    parameter int              PC_W        = 32,
    parameter logic [PC_W-1:0] VECTOR_ADDR = PC_W'(VECTOR_ADDR_DEFAULT)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [3:0]           exc_det,
    input  logic [3:0][4:0]      exc_code,
    input  logic [3:0][PC_W-1:0] exc_pc,
    input  logic [3:0]           exc_bd,
    input  logic                 eret_id,
    input  logic                 id_stall,
    exc_flush_ctrl_if.master     cp0_bus,
    output logic                 if_flush,
    output logic                 id_flush,
    output logic                 ex_flush,
    output logic                 m_flush,
    output logic                 pc_redirect,
    output logic [PC_W-1:0]      pc_redirect_addr,
    output logic                 busy,
    output exc_dbg_t             dbg
`ifdef EXC_CTRL_STATS_EN
    ,
    output logic [31:0]          exc_count,
    output logic [15:0]          eret_count
`endif
);

    exc_state_e      state;
    logic [1:0]      win_q;
    logic            post_rst;
    logic [PC_W-1:0] epc_q;
    logic [4:0]      code_q;
    logic            bd_q;

    logic            enc_valid;
    logic [1:0]      enc_idx;
    logic            eret_go;
    logic [PC_W-1:0] cap_pc;
    logic [PC_W-1:0] cap_epc;

    exc_prio_enc u_prio (
        .det   (exc_det),
        .valid (enc_valid),
        .idx   (enc_idx)
    );

    // An ERET only proceeds when nothing older (EX/M) is excepting; IF/ID
    // exceptions are handled by giving enc_valid priority in the FSM.
    assign eret_go = eret_id & ~id_stall & ~exc_det[STG_M] & ~exc_det[STG_EX];

    // A faulting branch-delay slot restarts at its branch, one word back.
    assign cap_pc  = exc_pc[enc_idx];
    assign cap_epc = exc_bd[enc_idx] ? (cap_pc - PC_W'(4)) : cap_pc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            win_q    <= 2'd0;
            post_rst <= 1'b1;
            epc_q    <= '0;
            code_q   <= 5'd0;
            bd_q     <= 1'b0;
        end else begin
            post_rst <= 1'b0;
            case (state)
                IDLE: begin
                    if (enc_valid) begin
                        state  <= EXC;
                        win_q  <= enc_idx;
                        epc_q  <= cap_epc;
                        code_q <= exc_code[enc_idx];
                        bd_q   <= exc_bd[enc_idx];
                    end else if (eret_go) begin
                        state <= ERET;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode from the registered state so reset drops every strobe
    // asynchronously. post_rst holds if_flush through reset and for the
    // first cycle after release.
    always_comb begin
        if_flush             = post_rst;
        id_flush             = 1'b0;
        ex_flush             = 1'b0;
        m_flush              = 1'b0;
        pc_redirect          = 1'b0;
        pc_redirect_addr     = '0;
        busy                 = 1'b0;
        cp0_bus.epc_we       = 1'b0;
        cp0_bus.cause_we     = 1'b0;
        cp0_bus.exl_set      = 1'b0;
        cp0_bus.exl_clr      = 1'b0;
        case (state)
            IDLE: begin
                m_flush  = exc_det[STG_M];
                ex_flush = |exc_det[STG_M:STG_EX];
                id_flush = |exc_det[STG_M:STG_ID];
                if_flush = post_rst | enc_valid | eret_go;
            end
            EXC: begin
                if_flush         = 1'b1;
                id_flush         = 1'b1;
                ex_flush         = 1'b1;
                m_flush          = 1'b1;
                pc_redirect      = 1'b1;
                pc_redirect_addr = VECTOR_ADDR;
                busy             = 1'b1;
                // A nested exception (EXL already set) must keep the
                // original return address.
                cp0_bus.epc_we   = ~cp0_bus.status_exl;
                cp0_bus.cause_we = 1'b1;
                cp0_bus.exl_set  = 1'b1;
            end
            ERET: begin
                if_flush         = 1'b1;
                id_flush         = 1'b1;
                pc_redirect      = 1'b1;
                pc_redirect_addr = cp0_bus.epc_in;
                busy             = 1'b1;
                cp0_bus.exl_clr  = 1'b1;
            end
            default: ;
        endcase
    end

    assign cp0_bus.epc_wdata     = epc_q;
    assign cp0_bus.cause_exccode = code_q;
    assign cp0_bus.cause_bd      = bd_q;

    assign dbg.state = state;
    assign dbg.win   = win_q;

`ifdef EXC_CTRL_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exc_count  <= 32'd0;
            eret_count <= 16'd0;
        end else if (state == IDLE) begin
            if (enc_valid) begin
                if (exc_count != 32'hFFFF_FFFF) begin
                    exc_count <= exc_count + 32'd1;
                end
            end else if (eret_go) begin
                if (eret_count != 16'hFFFF) begin
                    eret_count <= eret_count + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_exc_flush_ctrl.sv
// tb_exc_flush_ctrl: directed bench for exc_flush_ctrl. Inputs are driven
// on the falling edge and outputs sampled 1ns later.
module tb_exc_flush_ctrl;
    import cp0_pkg::*;

    localparam int PC_W = 32;
    localparam logic [31:0] VEC = 32'h8000_0180;

    logic                 clk;
    logic                 reset_n;
    logic [3:0]           exc_det;
    logic [3:0][4:0]      exc_code;
    logic [3:0][PC_W-1:0] exc_pc;
    logic [3:0]           exc_bd;
    logic                 eret_id;
    logic                 id_stall;
    logic                 if_flush, id_flush, ex_flush, m_flush;
    logic                 pc_redirect;
    logic [PC_W-1:0]      pc_redirect_addr;
    logic                 busy;
    exc_dbg_t             dbg;
`ifdef EXC_CTRL_STATS_EN
    logic [31:0]          exc_count;
    logic [15:0]          eret_count;
`endif

    int checks;
    int failures;

    exc_flush_ctrl_if #(.PC_W(PC_W)) bus ();

    exc_flush_ctrl #(.PC_W(PC_W)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .exc_det          (exc_det),
        .exc_code         (exc_code),
        .exc_pc           (exc_pc),
        .exc_bd           (exc_bd),
        .eret_id          (eret_id),
        .id_stall         (id_stall),
        .cp0_bus          (bus),
        .if_flush         (if_flush),
        .id_flush         (id_flush),
        .ex_flush         (ex_flush),
        .m_flush          (m_flush),
        .pc_redirect      (pc_redirect),
        .pc_redirect_addr (pc_redirect_addr),
        .busy             (busy),
        .dbg              (dbg)
`ifdef EXC_CTRL_STATS_EN
        ,
        .exc_count        (exc_count),
        .eret_count       (eret_count)
`endif
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic idle_inputs();
        exc_det        = 4'b0000;
        exc_code       = '0;
        exc_pc         = '0;
        exc_bd         = 4'b0000;
        eret_id        = 1'b0;
        id_stall       = 1'b0;
        bus.status_exl = 1'b0;
        bus.epc_in     = '0;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Scenario tasks
    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        step();
        step();
        checks++; if (if_flush !== 1'b1) begin failures++; $display("FAIL rst_if_flush got=%b exp=1", if_flush); end
        checks++; if ({id_flush, ex_flush, m_flush, pc_redirect, busy} !== 5'b0) begin failures++; $display("FAIL rst_outs got=%b exp=00000", {id_flush, ex_flush, m_flush, pc_redirect, busy}); end
        checks++; if ({bus.epc_we, bus.cause_we, bus.exl_set, bus.exl_clr} !== 4'b0) begin failures++; $display("FAIL rst_strobes got=%b exp=0000", {bus.epc_we, bus.cause_we, bus.exl_set, bus.exl_clr}); end
        checks++; if (dbg.state !== IDLE) begin failures++; $display("FAIL rst_state got=%0d exp=0", dbg.state); end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++; if (if_flush !== 1'b1) begin failures++; $display("FAIL post_rst_flush got=%b exp=1", if_flush); end
        step();
        checks++; if (if_flush !== 1'b0) begin failures++; $display("FAIL post_rst_flush_drop got=%b exp=0", if_flush); end
        checks++; if ({bus.epc_wdata, bus.cause_exccode, bus.cause_bd, pc_redirect_addr} !== '0) begin failures++; $display("FAIL rst_data got=%h/%h/%b/%h exp=0", bus.epc_wdata, bus.cause_exccode, bus.cause_bd, pc_redirect_addr); end
    endtask

    task automatic test_exc_ex();
        exc_det     = 4'b0100;
        exc_code[2] = 5'd12;
        exc_pc[2]   = 32'h0040_0010;
        #1;
        checks++; if ({if_flush, id_flush, ex_flush, m_flush} !== 4'b1110) begin failures++; $display("FAIL ex_flushes got=%b exp=1110", {if_flush, id_flush, ex_flush, m_flush}); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ex_busy_idle got=%b exp=0", busy); end
        step();
        exc_det = 4'b0000;
        checks++; if (bus.epc_wdata !== 32'h0040_0010) begin failures++; $display("FAIL ex_epc got=%h exp=00400010", bus.epc_wdata); end
        checks++; if ({bus.epc_we, bus.cause_we, bus.exl_set, bus.exl_clr} !== 4'b1110) begin failures++; $display("FAIL ex_strobes got=%b exp=1110", {bus.epc_we, bus.cause_we, bus.exl_set, bus.exl_clr}); end
        checks++; if (bus.cause_exccode !== 5'd12 || bus.cause_bd !== 1'b0) begin failures++; $display("FAIL ex_cause got=%0d/%b exp=12/0", bus.cause_exccode, bus.cause_bd); end
        checks++; if (pc_redirect !== 1'b1 || pc_redirect_addr !== VEC) begin failures++; $display("FAIL ex_redirect got=%b/%h exp=1/80000180", pc_redirect, pc_redirect_addr); end
        checks++; if ({if_flush, id_flush, ex_flush, m_flush, busy} !== 5'b11111) begin failures++; $display("FAIL ex_exc_flushes got=%b exp=11111", {if_flush, id_flush, ex_flush, m_flush, busy}); end
        step();
        checks++; if ({pc_redirect, busy, bus.epc_we, bus.cause_we, bus.exl_set} !== 5'b0) begin failures++; $display("FAIL ex_after got=%b exp=00000", {pc_redirect, busy, bus.epc_we, bus.cause_we, bus.exl_set}); end
    endtask

    task automatic test_exc_m_bd();
        exc_det     = 4'b1001;
        exc_code[3] = 5'd4;
        exc_pc[3]   = 32'h0040_0104;
        exc_bd[3]   = 1'b1;
        exc_code[0] = 5'd6;
        exc_pc[0]   = 32'h0000_1234;
        #1;
        checks++; if ({if_flush, id_flush, ex_flush, m_flush} !== 4'b1111) begin failures++; $display("FAIL m_flushes got=%b exp=1111", {if_flush, id_flush, ex_flush, m_flush}); end
        step();
        idle_inputs();
        checks++; if (bus.epc_wdata !== 32'h0040_0100) begin failures++; $display("FAIL m_epc got=%h exp=00400100", bus.epc_wdata); end
        checks++; if (bus.cause_bd !== 1'b1 || bus.cause_exccode !== 5'd4) begin failures++; $display("FAIL m_cause got=%b/%0d exp=1/4", bus.cause_bd, bus.cause_exccode); end
        checks++; if (dbg.win !== 2'd3 || dbg.state !== EXC) begin failures++; $display("FAIL m_dbg got=%0d/%0d exp=3/1", dbg.win, dbg.state); end
        step();
    endtask

    task automatic test_nested();
        bus.status_exl = 1'b1;
        exc_det        = 4'b0010;
        exc_code[1]    = 5'd10;
        exc_pc[1]      = 32'h0040_0050;
        #1;
        checks++; if ({if_flush, id_flush, ex_flush, m_flush} !== 4'b1100) begin failures++; $display("FAIL nest_flushes got=%b exp=1100", {if_flush, id_flush, ex_flush, m_flush}); end
        step();
        exc_det = 4'b0000;
        checks++; if ({bus.epc_we, bus.cause_we, bus.exl_set} !== 3'b011) begin failures++; $display("FAIL nest_strobes got=%b exp=011", {bus.epc_we, bus.cause_we, bus.exl_set}); end
        checks++; if (pc_redirect !== 1'b1 || pc_redirect_addr !== VEC || bus.cause_exccode !== 5'd10) begin failures++; $display("FAIL nest_redirect got=%b/%h/%0d exp=1/80000180/10", pc_redirect, pc_redirect_addr, bus.cause_exccode); end
        step();
        idle_inputs();
    endtask

    task automatic test_eret_stall();
        bus.status_exl = 1'b1;
        bus.epc_in     = 32'h0040_0200;
        eret_id        = 1'b1;
        id_stall       = 1'b1;
        #1;
        checks++; if (if_flush !== 1'b0) begin failures++; $display("FAIL eret_stall_flush got=%b exp=0", if_flush); end
        step();
        step();
        checks++; if (busy !== 1'b0 || pc_redirect !== 1'b0 || bus.exl_clr !== 1'b0) begin failures++; $display("FAIL eret_stall_hold got=%b/%b/%b exp=0/0/0", busy, pc_redirect, bus.exl_clr); end
        id_stall = 1'b0;
        #1;
        checks++; if ({if_flush, id_flush} !== 2'b10) begin failures++; $display("FAIL eret_go_flush got=%b exp=10", {if_flush, id_flush}); end
        step();
        eret_id = 1'b0;
        checks++; if (pc_redirect !== 1'b1 || pc_redirect_addr !== 32'h0040_0200) begin failures++; $display("FAIL eret_redirect got=%b/%h exp=1/00400200", pc_redirect, pc_redirect_addr); end
        checks++; if ({bus.exl_clr, bus.exl_set, bus.cause_we, bus.epc_we} !== 4'b1000) begin failures++; $display("FAIL eret_strobes got=%b exp=1000", {bus.exl_clr, bus.exl_set, bus.cause_we, bus.epc_we}); end
        checks++; if ({if_flush, id_flush, ex_flush, m_flush, busy} !== 5'b11001) begin failures++; $display("FAIL eret_flushes got=%b exp=11001", {if_flush, id_flush, ex_flush, m_flush, busy}); end
        step();
        checks++; if (pc_redirect !== 1'b0 || bus.exl_clr !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL eret_after got=%b/%b/%b exp=0/0/0", pc_redirect, bus.exl_clr, busy); end
        idle_inputs();
    endtask

    task automatic test_eret_vs_exc();
        bus.epc_in  = 32'h0040_0200;
        eret_id     = 1'b1;
        exc_det     = 4'b1000;
        exc_code[3] = 5'd13;
        exc_pc[3]   = 32'h0040_0300;
        step();
        exc_det = 4'b0000;
        eret_id = 1'b0;
        checks++; if (dbg.state !== EXC || bus.exl_clr !== 1'b0) begin failures++; $display("FAIL evx_state got=%0d/%b exp=1/0", dbg.state, bus.exl_clr); end
        checks++; if (pc_redirect_addr !== VEC || bus.epc_wdata !== 32'h0040_0300) begin failures++; $display("FAIL evx_target got=%h/%h exp=80000180/00400300", pc_redirect_addr, bus.epc_wdata); end
        step();
        checks++; if (bus.exl_clr !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL evx_after got=%b/%b exp=0/0", bus.exl_clr, busy); end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        exc_det     = 4'b0100;
        exc_code[2] = 5'd12;
        exc_pc[2]   = 32'h0040_0010;
        step();
        // Still in EXC: the new IF exception here is ignored this cycle and
        // must be taken from the following IDLE cycle.
        exc_det     = 4'b0001;
        exc_code[0] = 5'd4;
        exc_pc[0]   = 32'h0040_0400;
        checks++; if (bus.epc_wdata !== 32'h0040_0010 || busy !== 1'b1) begin failures++; $display("FAIL b2b_first got=%h/%b exp=00400010/1", bus.epc_wdata, busy); end
        step();
        checks++; if (busy !== 1'b0 || if_flush !== 1'b1 || id_flush !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b/%b/%b exp=0/1/0", busy, if_flush, id_flush); end
        step();
        exc_det = 4'b0000;
        checks++; if (busy !== 1'b1 || bus.epc_wdata !== 32'h0040_0400 || bus.cause_exccode !== 5'd4 || dbg.win !== 2'd0) begin failures++; $display("FAIL b2b_second got=%b/%h/%0d/%0d exp=1/00400400/4/0", busy, bus.epc_wdata, bus.cause_exccode, dbg.win); end
        step();
        idle_inputs();
    endtask

`ifdef EXC_CTRL_STATS_EN
    task automatic test_stats();
        // EXC entries: ex, m_bd, nested, eret_vs_exc, back_to_back x2.
        checks++; if (exc_count !== 32'd6 || eret_count !== 16'd1) begin failures++; $display("FAIL stats got=%0d/%0d exp=6/1", exc_count, eret_count); end
    endtask
`endif

    task automatic test_reset_mid_exc();
        exc_det     = 4'b0100;
        exc_code[2] = 5'd12;
        exc_pc[2]   = 32'h0040_0010;
        step();
        exc_det = 4'b0000;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rmid_busy got=%b exp=1", busy); end
        #1;
        reset_n = 1'b0;
        #1;
        checks++; if ({busy, pc_redirect, bus.epc_we, bus.cause_we, bus.exl_set, bus.exl_clr} !== 6'b0) begin failures++; $display("FAIL rmid_drop got=%b exp=000000", {busy, pc_redirect, bus.epc_we, bus.cause_we, bus.exl_set, bus.exl_clr}); end
        checks++; if ({if_flush, id_flush, ex_flush, m_flush} !== 4'b1000) begin failures++; $display("FAIL rmid_flushes got=%b exp=1000", {if_flush, id_flush, ex_flush, m_flush}); end
        step();
        reset_n = 1'b1;
        step();
        step();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_exc_ex();
        test_exc_m_bd();
        test_nested();
        test_eret_stall();
        test_eret_vs_exc();
        test_back_to_back();
`ifdef EXC_CTRL_STATS_EN
        test_stats();
`endif
        test_reset_mid_exc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exc_flush_ctrl.md
Name: exc_flush_ctrl

Overview:
- Exception/ERET sequencer for the 4-stage-plus-IF MIPS III pipeline.
- Sits beside cp0 and drives the per-stage flush lines that cp0 currently ties to 0.
- Selects the oldest excepting stage, issues the CP0 EPC/Cause/EXL writes, and sequences the PC redirect to the exception vector or to EPC on ERET.

Parameters:
- PC_W, 32, width of PC, EPC and vector.
- VECTOR_ADDR, 32'h8000_0180, general exception vector.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- exc_det  in  4  per-stage exception detect; index 0=IF, 1=ID, 2=EX, 3=M.
- exc_code  in  4x5  per-stage ExcCode.
- exc_pc  in  4xPC_W  per-stage instruction PC.
- exc_bd  in  4  per-stage branch-delay-slot flag.
- eret_id  in  1  ERET decoded in ID.
- id_stall  in  1  ID stage stalled.
- status_exl  in  1  current Status.EXL.
- epc_in  in  PC_W  current EPC.
- if_flush, id_flush, ex_flush, m_flush  out  1 each  stage flushes.
- pc_redirect  out  1  fetch must load pc_redirect_addr.
- pc_redirect_addr  out  PC_W  redirect target.
- epc_we  out  1  EPC write strobe.
- epc_wdata  out  PC_W  EPC write data.
- cause_we  out  1  Cause write strobe.
- cause_exccode  out  5  Cause.ExcCode data.
- cause_bd  out  1  Cause.BD data.
- exl_set, exl_clr  out  1 each  Status.EXL set/clear strobes.
- busy  out  1  sequencer not IDLE.

Behaviour:
- Reset: all outputs 0 except if_flush, state=IDLE.
  - if_flush=1 while reset_n=0 and for exactly one cycle after deassertion (post-reset flush flop).
- Priority: M > EX > ID > IF (oldest wins). Winner index w, registered at capture.
- Combinational flushes in IDLE:
  - m_flush = det[3]
  - ex_flush = det[3] | det[2]
  - id_flush = det[3..1] ORed
  - if_flush = any det | eret_go | post-reset flag
  - eret_go = eret_id & ~id_stall & ~det[3] & ~det[2]
- States:
  - IDLE, any det → EXC (next edge). Capture epc_wdata = exc_bd[w] ? exc_pc[w]-4 : exc_pc[w] (mod 2^PC_W), cause_exccode, cause_bd.
  - IDLE, eret_go with no det → ERET.
  - EXC (1 cycle): cause_we=1, exl_set=1, epc_we=~status_exl (nested exception keeps EPC), pc_redirect=1 with VECTOR_ADDR, all four flushes=1 → IDLE.
  - ERET (1 cycle): pc_redirect=1 with epc_in, exl_clr=1, if_flush=1, id_flush=1 → IDLE.
- Outside EXC/ERET, all strobes and pc_redirect are 0; busy=1 in EXC and ERET.
- In EXC/ERET, exc_det and eret_id are ignored (the flushed stages are invalid).
- Simultaneous events:
  - ERET vs det[3]/det[2] in the same cycle: exception wins, ERET is dropped.
  - ERET vs det[1]/det[0] only (IF/ID): exception wins. ERET is in ID and is flushed.
  - eret_id with id_stall=1: no action until the stall clears.
- Back-to-back exceptions: a new det in the cycle after EXC returns to IDLE is accepted normally.
- Reset asserted mid-EXC/ERET: immediate return to IDLE, strobes drop asynchronously.

Optional Feature:
- Macro EXC_CTRL_STATS_EN.
- When defined:
  - Adds output exc_count [31:0], a saturating count of EXC entries. Reset 0; holds at 32'hFFFF_FFFF.
  - Adds output eret_count [15:0] with the same saturating rule for ERET entries.
- When undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- cp0_pkg holds:
  - stage index constants STG_IF..STG_M.
  - ExcCode constants (Int, AdEL, AdES, Sys, Bp, RI, Ov).
  - enum exc_state_e {IDLE, EXC, ERET}.
  - VECTOR_ADDR default.
- One sub-module, exc_prio_enc: 4-bit oldest-first priority encoder giving valid plus a 2-bit index.

Test Plan:
- Reset release → if_flush=1 for exactly one cycle, then 0; all other outputs 0.
- det[2]=1, code=5'd12, pc=32'h0040_0010, bd=0, status_exl=0 → same cycle: ex/id/if/m flushes=1,0… (m_flush=0, others 1). Next cycle: epc_wdata=32'h0040_0010, epc_we=1, cause_exccode=12, exl_set=1, pc_redirect=1 to 32'h8000_0180.
- det[3] with bd=1 and pc=32'h0040_0104, plus det[0] in the same cycle → M wins; epc_wdata=32'h0040_0100, cause_bd=1.
- status_exl=1, det[1] → epc_we=0, cause_we=1, redirect to vector.
- eret_id=1, id_stall=1 for 2 cycles, then 0, epc_in=32'h0040_0200 → one-cycle ERET: pc_redirect to 32'h0040_0200, exl_clr=1.
  - Repeat with det[3]=1 in the same cycle → exception taken, exl_clr never pulses.
- reset_n low during EXC → all strobes 0 immediately; busy=0.
